// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
//   Burst controller in front of a synchronous single-port RAM. A host request
//   (start address + length) is turned into a write burst, paced by the host's
//   Wr_valid beats, or a back-to-back read burst whose data returns on
//   Rd_data/Rd_valid two cycles after each read command.
//
//   Optional feature macro: RAM_CTRL_BOUND_EN
//     defined   : bursts running past DEPTH-1 are accepted, issue no commands,
//                 and raise a one-cycle Err pulse.
//     undefined : addresses wrap from DEPTH-1 to 0 and Err is tied low.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   Req_valid/Req_ready      request handshake (Req_ready only in IDLE)
//   Req_write                1 = write burst, 0 = read burst
//   Req_addr, Req_len        burst start address, length minus one
//   Wr_data/Wr_valid/Wr_ready write beat stream
//   Rd_data/Rd_valid         read beat stream (no backpressure)
//   Busy, Err                not-IDLE flag, bound-error pulse
//   Mem_CS, Mem_W_R, Mem_Address, Mem_Data_in, Mem_Data_out  RAM port
//
// state | meaning
// IDLE  | waiting for a request, Req_ready high
// WRITE | one RAM write per accepted Wr_valid beat
// READ  | one RAM read command per cycle (Mem_CS high in this state)
// DRAIN | waiting for the last read data to leave the pipeline, or Err cycle
module ram_access_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Req_valid,
  output logic                  Req_ready,
  input  logic                  Req_write,
  input  logic [ADDR_WIDTH-1:0] Req_addr,
  input  logic [ADDR_WIDTH-1:0] Req_len,
  input  logic [DATA_WIDTH-1:0] Wr_data,
  input  logic                  Wr_valid,
  output logic                  Wr_ready,
  output logic [DATA_WIDTH-1:0] Rd_data,
  output logic                  Rd_valid,
  output logic                  Busy,
  output logic                  Err,
  output logic                  Mem_CS,
  output logic                  Mem_W_R,
  output logic [ADDR_WIDTH-1:0] Mem_Address,
  output logic [DATA_WIDTH-1:0] Mem_Data_in,
  input  logic [DATA_WIDTH-1:0] Mem_Data_out
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    drain_q, drain_d;
  logic                    req_ready_q, req_ready_d;
  logic                    mem_cs_q, mem_cs_d;
  logic                    mem_w_r_q, mem_w_r_d;
  logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0]   mem_data_in_q, mem_data_in_d;
  logic                    rd_pend_q, rd_pend_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    err_q, err_d;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_WIDTH'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

`ifdef RAM_CTRL_BOUND_EN
  logic [ADDR_WIDTH:0] end_addr;
  logic                oob;
  assign end_addr = {1'b0, Req_addr} + {1'b0, Req_len};
  assign oob      = end_addr > (ADDR_WIDTH + 1)'(DEPTH - 1);
`endif

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    drain_d       = drain_q;
    mem_cs_d      = 1'b0;
    mem_w_r_d     = 1'b0;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    err_d         = 1'b0;
    // Registered RAM read: command in C, data on Mem_Data_out in C+1,
    // captured at the end of C+1 so Rd_valid is high in C+2.
    rd_pend_d     = mem_cs_q & ~mem_w_r_q;
    rd_valid_d    = rd_pend_q;
    rd_data_d     = rd_pend_q ? Mem_Data_out : rd_data_q;

    unique case (state_q)
      IDLE: begin
        if (Req_valid && req_ready_q) begin
          cnt_d = Req_len;
`ifdef RAM_CTRL_BOUND_EN
          // One DRAIN cycle carries the Err pulse, then back to IDLE.
          if (oob) begin
            state_d = DRAIN;
            drain_d = 1'b0;
            err_d   = 1'b1;
          end else
`endif
          if (Req_write) begin
            state_d = WRITE;
            addr_d  = Req_addr;
          end else begin
            // First read command goes out on the edge that enters READ, so
            // READ cycles and command cycles coincide.
            state_d       = READ;
            mem_cs_d      = 1'b1;
            mem_address_d = Req_addr;
            addr_d        = next_addr(Req_addr);
          end
        end
      end
      WRITE: begin
        if (Wr_valid) begin
          mem_cs_d      = 1'b1;
          mem_w_r_d     = 1'b1;
          mem_address_d = addr_q;
          mem_data_in_d = Wr_data;
          addr_d        = next_addr(addr_q);
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      READ: begin
        if (cnt_q == '0) begin
          state_d = DRAIN;
          drain_d = 1'b1;
        end else begin
          mem_cs_d      = 1'b1;
          mem_address_d = addr_q;
          addr_d        = next_addr(addr_q);
          cnt_d         = cnt_q - 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == 1'b0) state_d = IDLE;
        else                 drain_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      cnt_q         <= '0;
      drain_q       <= 1'b0;
      req_ready_q   <= 1'b0;
      mem_cs_q      <= 1'b0;
      mem_w_r_q     <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      rd_pend_q     <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      drain_q       <= drain_d;
      req_ready_q   <= req_ready_d;
      mem_cs_q      <= mem_cs_d;
      mem_w_r_q     <= mem_w_r_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      rd_pend_q     <= rd_pend_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
      err_q         <= err_d;
    end
  end

  assign Req_ready   = req_ready_q;
  assign Wr_ready    = (state_q == WRITE);
  assign Busy        = (state_q != IDLE);
  assign Rd_valid    = rd_valid_q;
  assign Rd_data     = rd_data_q;
  assign Mem_CS      = mem_cs_q;
  assign Mem_W_R     = mem_w_r_q;
  assign Mem_Address = mem_address_q;
  assign Mem_Data_in = mem_data_in_q;
`ifdef RAM_CTRL_BOUND_EN
  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural synchronous RAM.
module tb_ram_access_ctrl;

  logic       CLK;
  logic       RST;
  logic       Req_valid;
  logic       Req_ready;
  logic       Req_write;
  logic [7:0] Req_addr;
  logic [7:0] Req_len;
  logic [7:0] Wr_data;
  logic       Wr_valid;
  logic       Wr_ready;
  logic [7:0] Rd_data;
  logic       Rd_valid;
  logic       Busy;
  logic       Err;
  logic       Mem_CS;
  logic       Mem_W_R;
  logic [7:0] Mem_Address;
  logic [7:0] Mem_Data_in;
  logic [7:0] Mem_Data_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];

  ram_access_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(256)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .Req_valid    (Req_valid),
    .Req_ready    (Req_ready),
    .Req_write    (Req_write),
    .Req_addr     (Req_addr),
    .Req_len      (Req_len),
    .Wr_data      (Wr_data),
    .Wr_valid     (Wr_valid),
    .Wr_ready     (Wr_ready),
    .Rd_data      (Rd_data),
    .Rd_valid     (Rd_valid),
    .Busy         (Busy),
    .Err          (Err),
    .Mem_CS       (Mem_CS),
    .Mem_W_R      (Mem_W_R),
    .Mem_Address  (Mem_Address),
    .Mem_Data_in  (Mem_Data_in),
    .Mem_Data_out (Mem_Data_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM contents are preset to addr ^ 0x5A while RST is high.
  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
      Mem_Data_out <= 8'h00;
    end else if (Mem_CS) begin
      if (Mem_W_R) mem[Mem_Address] <= Mem_Data_in;
      else         Mem_Data_out     <= mem[Mem_Address];
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; Req_valid = 1'b0; Req_write = 1'b0; Req_addr = 8'h00; Req_len = 8'h00;
    Wr_data = 8'h00; Wr_valid = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", 32'(Req_ready), 0);
    chk("rst_wr_ready",  32'(Wr_ready), 0);
    chk("rst_busy",      32'(Busy), 0);
    chk("rst_err",       32'(Err), 0);
    chk("rst_rd_valid",  32'(Rd_valid), 0);
    chk("rst_rd_data",   32'(Rd_data), 0);
    chk("rst_mem_cs",    32'(Mem_CS), 0);
    chk("rst_mem_w_r",   32'(Mem_W_R), 0);
    chk("rst_mem_addr",  32'(Mem_Address), 0);
    chk("rst_mem_din",   32'(Mem_Data_in), 0);
    RST = 1'b0;
    tick();
    chk("post_rst_ready", 32'(Req_ready), 1);

    // Write burst 0x10..0x13, data 0xA1..0xA4 back to back.
    Req_valid = 1'b1; Req_write = 1'b1; Req_addr = 8'h10; Req_len = 8'd3;
    tick();
    chk("wr_state_wr_ready", 32'(Wr_ready), 1);
    chk("wr_state_busy",     32'(Busy), 1);
    chk("wr_state_req_rdy",  32'(Req_ready), 0);
    chk("wr_state_no_cs",    32'(Mem_CS), 0);
    Req_valid = 1'b0;
    Wr_valid = 1'b1; Wr_data = 8'hA1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wr_cs",   32'(Mem_CS), 1);
      chk("wr_w_r",  32'(Mem_W_R), 1);
      chk("wr_addr", 32'(Mem_Address), 32'h10 + i);
      chk("wr_data", 32'(Mem_Data_in), 32'hA1 + i);
      chk("wr_busy", 32'(Busy), 32'(i < 3));
      Wr_data = 8'(8'hA2 + i);
    end
    Wr_valid = 1'b0;
    chk("wr_done_ready",    32'(Req_ready), 1);
    chk("wr_done_wr_ready", 32'(Wr_ready), 0);

    // Read back in the first IDLE cycle; stray Req_valid/Wr_valid are ignored.
    Req_valid = 1'b1; Req_write = 1'b0; Req_addr = 8'h10; Req_len = 8'd3;
    tick();
    Req_write = 1'b1; Wr_valid = 1'b1; Wr_data = 8'h77;
    for (int k = 0; k < 7; k++) begin
      chk("rd_cs", 32'(Mem_CS), 32'(k < 4));
      if (k < 4) begin
        chk("rd_addr", 32'(Mem_Address), 32'h10 + k);
        chk("rd_w_r",  32'(Mem_W_R), 0);
      end
      chk("rd_valid", 32'(Rd_valid), 32'(k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) chk("rd_data", 32'(Rd_data), 32'hA1 + k - 2);
      chk("rd_busy",     32'(Busy), 32'(k < 6));
      chk("rd_wr_ready", 32'(Wr_ready), 0);
      chk("rd_err",      32'(Err), 0);
      if (k == 5) begin
        Req_valid = 1'b0; Req_write = 1'b0; Wr_valid = 1'b0;
      end
      if (k < 6) tick();
    end
    chk("rd_idle_ready", 32'(Req_ready), 1);

    // Two-beat write with two idle cycles between the beats.
    Req_valid = 1'b1; Req_write = 1'b1; Req_addr = 8'h10; Req_len = 8'd1;
    tick();
    Req_valid = 1'b0;
    Wr_valid = 1'b1; Wr_data = 8'hB1;
    tick();
    chk("gap_cs1",   32'(Mem_CS), 1);
    chk("gap_addr1", 32'(Mem_Address), 32'h10);
    chk("gap_data1", 32'(Mem_Data_in), 32'hB1);
    Wr_valid = 1'b0; Wr_data = 8'hEE;
    tick();
    chk("gap_idle_cs",   32'(Mem_CS), 0);
    chk("gap_idle_w_r",  32'(Mem_W_R), 0);
    chk("gap_hold_addr", 32'(Mem_Address), 32'h10);
    chk("gap_hold_data", 32'(Mem_Data_in), 32'hB1);
    chk("gap_wr_ready",  32'(Wr_ready), 1);
    tick();
    chk("gap_idle_cs2", 32'(Mem_CS), 0);
    chk("gap_busy",     32'(Busy), 1);
    Wr_valid = 1'b1; Wr_data = 8'hB2;
    tick();
    chk("gap_cs2",   32'(Mem_CS), 1);
    chk("gap_w_r2",  32'(Mem_W_R), 1);
    chk("gap_addr2", 32'(Mem_Address), 32'h11);
    chk("gap_data2", 32'(Mem_Data_in), 32'hB2);
    chk("gap_done",  32'(Busy), 0);
    Wr_valid = 1'b0;

    // Read 0xFE, len 2: wraps, or bound error when the feature is built in.
    Req_valid = 1'b1; Req_write = 1'b0; Req_addr = 8'hFE; Req_len = 8'd2;
    tick();
    Req_valid = 1'b0;
`ifdef RAM_CTRL_BOUND_EN
    chk("oob_cs",      32'(Mem_CS), 0);
    chk("oob_err",     32'(Err), 1);
    chk("oob_busy",    32'(Busy), 1);
    chk("oob_wr_rdy",  32'(Wr_ready), 0);
    tick();
    chk("oob_cs2",     32'(Mem_CS), 0);
    chk("oob_err2",    32'(Err), 0);
    chk("oob_idle",    32'(Busy), 0);
    chk("oob_ready",   32'(Req_ready), 1);
    tick();
    chk("oob_rd_valid", 32'(Rd_valid), 0);
`else
    for (int k = 0; k < 6; k++) begin
      chk("wrap_cs", 32'(Mem_CS), 32'(k < 3));
      if (k < 3) chk("wrap_addr", 32'(Mem_Address), (32'hFE + k) & 32'hFF);
      chk("wrap_valid", 32'(Rd_valid), 32'(k >= 2 && k <= 4));
      if (k >= 2 && k <= 4) chk("wrap_data", 32'(Rd_data), ((32'hFE + k - 2) & 32'hFF) ^ 32'h5A);
      chk("wrap_err",  32'(Err), 0);
      chk("wrap_busy", 32'(Busy), 32'(k < 5));
      if (k < 5) tick();
    end
`endif

    // Reset during the second beat of a four-beat read aborts the burst.
    Req_valid = 1'b1; Req_write = 1'b0; Req_addr = 8'h20; Req_len = 8'd3;
    tick();
    Req_valid = 1'b0;
    chk("abort_cs0",   32'(Mem_CS), 1);
    chk("abort_addr0", 32'(Mem_Address), 32'h20);
    tick();
    chk("abort_addr1", 32'(Mem_Address), 32'h21);
    RST = 1'b1;
    tick();
    chk("abort_cs",       32'(Mem_CS), 0);
    chk("abort_rd_valid", 32'(Rd_valid), 0);
    chk("abort_busy",     32'(Busy), 0);
    chk("abort_ready",    32'(Req_ready), 0);
    chk("abort_addr_rst", 32'(Mem_Address), 0);
    RST = 1'b0;
    tick();
    chk("abort_ready_after", 32'(Req_ready), 1);
    chk("abort_cs_after",    32'(Mem_CS), 0);
    chk("abort_rv_after",    32'(Rd_valid), 0);
    tick();
    chk("abort_rv_after2", 32'(Rd_valid), 0);
    chk("abort_cs_after2", 32'(Mem_CS), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_access_ctrl.md
RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 Parameters (name, default, meaning): ADDR_WIDTH, 8, RAM address bits; DATA_WIDTH, 8, RAM word bits; DEPTH, 256, RAM words (= 2^ADDR_WIDTH).
REQ-002 CLK  in  1  sole clock; every flop SHALL update on its rising edge.
REQ-003 RST  in  1  reset; synchronous and active-high.
REQ-004 Req_valid  in  1  host request present.
REQ-005 Req_ready  out  1  controller can accept a request.
REQ-006 Req_write  in  1  1 = write burst, 0 = read burst.
REQ-007 Req_addr  in  ADDR_WIDTH  burst start address.
REQ-008 Req_len  in  ADDR_WIDTH  burst length minus one (words = Req_len+1).
REQ-009 Wr_data  in  DATA_WIDTH  write beat data; Wr_valid in 1 beat present; Wr_ready out 1 beat accepted.
REQ-010 Rd_data  out  DATA_WIDTH  read beat data; Rd_valid out 1 beat valid (no backpressure).
REQ-011 Busy  out  1  high whenever state is not IDLE; Err out 1 one-cycle error pulse.
REQ-012 Mem_CS, Mem_W_R out 1; Mem_Address out ADDR_WIDTH; Mem_Data_in out DATA_WIDTH; Mem_Data_out in DATA_WIDTH: drives a synchronous single-port RAM (chip select, 1 = write, registered one-cycle read).

Function
REQ-013 FSM states SHALL be IDLE, WRITE, READ, DRAIN; Req_ready SHALL be 1 only in IDLE.
REQ-014 In IDLE, Req_valid=1 SHALL latch Req_addr, Req_len and Req_write, and SHALL move to WRITE or READ on the next edge.
REQ-015 All Mem_* outputs SHALL be registered; a "command cycle" is a cycle with Mem_CS=1.
REQ-016 In WRITE: Wr_ready=1. Each beat with Wr_valid=1 SHALL yield one command cycle on the next cycle: Mem_W_R=1, current address, Wr_data. A cycle with Wr_valid=0 SHALL yield Mem_CS=0 and no address advance.
REQ-017 In WRITE, after the beat with index Req_len is accepted, the FSM SHALL return to IDLE; Wr_ready SHALL be 0 in every other state.
REQ-018 In READ: one command cycle (Mem_W_R=0) SHALL be issued per cycle for Req_len+1 consecutive cycles, then the FSM SHALL enter DRAIN.
REQ-019 For a read command in cycle C, Rd_data SHALL capture Mem_Data_out at the end of C+1, and Rd_valid SHALL be 1 in cycle C+2. Read beats SHALL be returned in address order with no gaps.
REQ-020 DRAIN SHALL last exactly 2 cycles, until the last Rd_valid has been issued, and then go to IDLE.
REQ-021 The address SHALL increment by 1 per issued command and wrap from DEPTH-1 to 0.
REQ-022 When Mem_CS=0, Mem_Address and Mem_Data_in SHALL hold their last values and Mem_W_R SHALL be 0.
REQ-023 Req_valid SHALL be ignored outside IDLE, and Wr_valid SHALL be ignored outside WRITE.
REQ-024 Minimum turnaround: a new request SHALL be accepted in the first IDLE cycle after a burst.

Reset
REQ-025 While RST=1 on an edge, the FSM SHALL enter IDLE and all of the following SHALL be 0 on the next cycle: Req_ready, Wr_ready, Rd_valid, Rd_data, Busy, Err, Mem_CS, Mem_W_R, Mem_Address, Mem_Data_in.
REQ-026 Reset mid-burst SHALL abort the burst: no further command cycles, and no Rd_valid for reads already issued.
REQ-027 Req_ready SHALL rise in the first cycle after RST is deasserted.

Configuration
REQ-028 Macro RAM_CTRL_BOUND_EN controls bound checking.
- Defined: a request with Req_addr+Req_len > DEPTH-1 SHALL be accepted but SHALL issue no command cycles. Err=1 for one cycle after acceptance, then IDLE; Wr_ready stays 0.
- Undefined: wrap per REQ-021 applies, and Err SHALL be constant 0.

Verification
REQ-029 Write Req_addr=0x10, Req_len=3, Wr_data 0xA1..0xA4 back-to-back -> four consecutive command cycles, Mem_W_R=1, addresses 0x10..0x13, data 0xA1..0xA4, then IDLE.
REQ-030 Read Req_addr=0x10, Req_len=3 after REQ-029 -> commands on C..C+3, Rd_valid on C+2..C+5, Rd_data 0xA1..0xA4, Busy low at C+6.
REQ-031 Write Req_len=1 with Wr_valid low for 2 cycles between beats -> Mem_CS low for exactly those 2 cycles, with address 0x11 on the second write.
REQ-032 Read Req_addr=0xFE, Req_len=2 without the macro -> addresses 0xFE, 0xFF, 0x00. With RAM_CTRL_BOUND_EN -> no command cycles and one Err pulse.
REQ-033 RST=1 during the second beat of a 4-beat read -> Mem_CS=0 and Rd_valid=0 from the next cycle on, and Req_ready=1 in the first cycle after RST falls.
